// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types for the D-cache miss path. Contains the coherence
//               request message, the MSHR entry state and an MSHR entry record
//               at the default cache geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int DC_TAG_W  = 10;
    localparam int DC_IDX_W  = 3;
    localparam int DC_WORD_W = 64;

    // Bus request message. GET_S must stay encoded as zero so that an idle
    // request port reads as all-zero.
    typedef enum logic [1:0] {
        GET_S = 2'd0,
        GET_M = 2'd1,
        PUT_M = 2'd2,
        PUT_S = 2'd3
    } message_t;

    typedef enum logic [1:0] {
        MSHR_INVALID = 2'd0,
        MSHR_PENDING = 2'd1,
        MSHR_ISSUED  = 2'd2,
        MSHR_FILL    = 2'd3
    } mshr_state_t;

    // One miss-status holding register at the default geometry.
    typedef struct packed {
        mshr_state_t          state;
        logic [DC_TAG_W-1:0]  tag;
        logic [DC_IDX_W-1:0]  idx;
        logic                 dty;
        message_t             msg;
        logic [DC_WORD_W-1:0] data;
    } mshr_entry_t;

endpackage
`default_nettype wire

// File: rtl/mshr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mshr_rr_arbiter
// Description : Round-robin grant over N request lines. The search starts at
//               the pointer and wraps; once a grant is presented it is held
//               until accepted so the downstream request stays stable.
// Ports       : clk, rst (async, active-low)
//               req[N]      - request vector
//               ack         - grant accepted this cycle
//               grant_vld   - a grant is presented
//               grant_id    - granted index
// Revision    : 1.0 - initial release
// ============================================================================
module mshr_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic            grant_vld,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;
    logic            held;
    logic [ID_W-1:0] held_id;
    logic [ID_W-1:0] cand;

    // Held grants take precedence: a newly pending entry that sorts ahead of
    // the presented one must not pre-empt a request the bus is looking at.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (held) begin
            grant_vld = 1'b1;
            grant_id  = held_id;
        end else begin
            // Descending scan so the smallest offset from ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                cand = ptr + ID_W'(k);
                if (req[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            held    <= 1'b0;
            held_id <= '0;
        end else if (ack && grant_vld) begin
            ptr  <= grant_id + ID_W'(1);
            held <= 1'b0;
        end else if (grant_vld) begin
            held    <= 1'b1;
            held_id <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_mshr_file.sv
`default_nettype none
// ============================================================================
// Module      : dcache_mshr_file
// Description : Non-blocking miss-status holding register file. Tracks up to
//               MSHR_NUM outstanding line misses, merges secondary misses to
//               in-flight lines, issues bus requests round-robin, matches
//               responses by entry id and replays completed lines as fills.
// Ports       : clk, rst (async, active-low)
//               alloc_*     - miss request from the controller, ack/merge back
//               full_o      - no free entry
//               bus_req_*   - bus request channel (held until bus_req_ack_i)
//               bus_rsp_*   - bus response channel, bus_rsp_ack_o when consumed
//               fill_*      - one-cycle fill pulse towards the cache memory
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_mshr_file
    import dcache_pkg::*;
#(
    parameter  int MSHR_NUM = 4,
    parameter  int TAG_W    = DC_TAG_W,
    parameter  int IDX_W    = DC_IDX_W,
    parameter  int WORD_W   = DC_WORD_W,
    localparam int ID_W     = $clog2(MSHR_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_i,
    input  logic [TAG_W-1:0]  alloc_tag_i,
    input  logic [IDX_W-1:0]  alloc_idx_i,
    input  logic              alloc_st_i,
    input  logic [WORD_W-1:0] alloc_data_i,
    output logic              alloc_ack_o,
    output logic              alloc_merge_o,
    output logic              full_o,
    output logic              bus_req_en_o,
    output logic [TAG_W-1:0]  bus_req_tag_o,
    output logic [IDX_W-1:0]  bus_req_idx_o,
    output logic [ID_W-1:0]   bus_req_id_o,
    output message_t          bus_req_message_o,
    input  logic              bus_req_ack_i,
    input  logic              bus_rsp_vld_i,
    input  logic [ID_W-1:0]   bus_rsp_id_i,
    input  logic [WORD_W-1:0] bus_rsp_data_i,
    output logic              bus_rsp_ack_o,
    output logic              fill_en_o,
    output logic [TAG_W-1:0]  fill_tag_o,
    output logic [IDX_W-1:0]  fill_idx_o,
    output logic [WORD_W-1:0] fill_data_o,
    output logic              fill_dty_o
);

    // Entry storage
    mshr_state_t       ent_state [MSHR_NUM];
    logic [TAG_W-1:0]  ent_tag   [MSHR_NUM];
    logic [IDX_W-1:0]  ent_idx   [MSHR_NUM];
    logic              ent_dty   [MSHR_NUM];
    message_t          ent_msg   [MSHR_NUM];
    logic [WORD_W-1:0] ent_data  [MSHR_NUM];

    logic [MSHR_NUM-1:0] pend_vec;
    logic                match_any;
    logic [ID_W-1:0]     match_id;
    logic                free_any;
    logic [ID_W-1:0]     free_id;
    logic                fill_any;
    logic [ID_W-1:0]     fill_id;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic                issue_fire;
    logic                rsp_fire;
    logic                do_new;
    logic                do_merge_st;

    // Line match plus the two lowest-index priority encoders. Descending scans
    // leave the lowest matching index in the result.
    always_comb begin
        pend_vec  = '0;
        match_any = 1'b0;
        match_id  = '0;
        free_any  = 1'b0;
        free_id   = '0;
        fill_any  = 1'b0;
        fill_id   = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            pend_vec[i] = (ent_state[i] == MSHR_PENDING);
            if (ent_state[i] != MSHR_INVALID &&
                ent_tag[i] == alloc_tag_i && ent_idx[i] == alloc_idx_i) begin
                match_any = 1'b1;
                match_id  = ID_W'(i);
            end
            if (ent_state[i] == MSHR_INVALID) begin
                free_any = 1'b1;
                free_id  = ID_W'(i);
            end
            if (ent_state[i] == MSHR_FILL) begin
                fill_any = 1'b1;
                fill_id  = ID_W'(i);
            end
        end
    end

    mshr_rr_arbiter #(
        .N    (MSHR_NUM),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend_vec),
        .ack       (bus_req_ack_i),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    assign issue_fire = grant_vld & bus_req_ack_i;
    assign rsp_fire   = bus_rsp_vld_i & (ent_state[bus_rsp_id_i] == MSHR_ISSUED);

    // Allocate / merge decision. A store may only join a line whose request
    // will (or already did) go out as GET_M; upgrading a GET_S that the bus
    // accepts in this very cycle would be lost, so that case stalls.
    always_comb begin
        alloc_ack_o   = 1'b0;
        alloc_merge_o = 1'b0;
        do_new        = 1'b0;
        do_merge_st   = 1'b0;
        if (alloc_en_i) begin
            if (match_any) begin
                case (ent_state[match_id])
                    MSHR_PENDING: begin
                        if (!(alloc_st_i && ent_msg[match_id] == GET_S &&
                              issue_fire && grant_id == match_id)) begin
                            alloc_ack_o   = 1'b1;
                            alloc_merge_o = 1'b1;
                            do_merge_st   = alloc_st_i;
                        end
                    end
                    MSHR_ISSUED: begin
                        if (!alloc_st_i || ent_msg[match_id] == GET_M) begin
                            alloc_ack_o   = 1'b1;
                            alloc_merge_o = 1'b1;
                            do_merge_st   = alloc_st_i;
                        end
                    end
                    default: ;  // FILL: stall until the entry frees
                endcase
            end else if (free_any) begin
                alloc_ack_o = 1'b1;
                do_new      = 1'b1;
            end
        end
    end

    assign full_o        = ~free_any;
    assign bus_rsp_ack_o = rsp_fire;

    assign bus_req_en_o      = grant_vld;
    assign bus_req_id_o      = grant_vld ? grant_id : '0;
    assign bus_req_tag_o     = grant_vld ? ent_tag[grant_id] : '0;
    assign bus_req_idx_o     = grant_vld ? ent_idx[grant_id] : '0;
    assign bus_req_message_o = grant_vld ? ent_msg[grant_id] : GET_S;

    assign fill_en_o   = fill_any;
    assign fill_tag_o  = fill_any ? ent_tag[fill_id]  : '0;
    assign fill_idx_o  = fill_any ? ent_idx[fill_id]  : '0;
    assign fill_data_o = fill_any ? ent_data[fill_id] : '0;
    assign fill_dty_o  = fill_any ? ent_dty[fill_id]  : 1'b0;

    // Every event targets a distinct entry state (PENDING, ISSUED, FILL,
    // INVALID), so the per-entry updates below never collide on state. The
    // store merge is placed last so its data wins over a response landing on
    // the same entry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                ent_state[i] <= MSHR_INVALID;
                ent_tag[i]   <= '0;
                ent_idx[i]   <= '0;
                ent_dty[i]   <= 1'b0;
                ent_msg[i]   <= GET_S;
                ent_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                if (issue_fire && grant_id == ID_W'(i)) begin
                    ent_state[i] <= MSHR_ISSUED;
                end
                if (rsp_fire && bus_rsp_id_i == ID_W'(i)) begin
                    ent_state[i] <= MSHR_FILL;
                    ent_data[i]  <= ent_dty[i] ? ent_data[i] : bus_rsp_data_i;
                end
                if (fill_any && fill_id == ID_W'(i)) begin
                    ent_state[i] <= MSHR_INVALID;
                end
                if (do_new && free_id == ID_W'(i)) begin
                    ent_state[i] <= MSHR_PENDING;
                    ent_tag[i]   <= alloc_tag_i;
                    ent_idx[i]   <= alloc_idx_i;
                    ent_dty[i]   <= alloc_st_i;
                    ent_msg[i]   <= alloc_st_i ? GET_M : GET_S;
                    ent_data[i]  <= alloc_st_i ? alloc_data_i : '0;
                end
                if (do_merge_st && match_id == ID_W'(i)) begin
                    ent_dty[i]  <= 1'b1;
                    ent_msg[i]  <= GET_M;
                    ent_data[i] <= alloc_data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_mshr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_mshr_file
// Description : Directed self-checking bench for dcache_mshr_file. Inputs are
//               driven at the falling edge and outputs sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_mshr_file;
    import dcache_pkg::*;

    localparam int MSHR_NUM = 4;
    localparam int TAG_W    = 10;
    localparam int IDX_W    = 3;
    localparam int WORD_W   = 64;
    localparam int ID_W     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_en_i;
    logic [TAG_W-1:0]  alloc_tag_i;
    logic [IDX_W-1:0]  alloc_idx_i;
    logic              alloc_st_i;
    logic [WORD_W-1:0] alloc_data_i;
    logic              alloc_ack_o;
    logic              alloc_merge_o;
    logic              full_o;
    logic              bus_req_en_o;
    logic [TAG_W-1:0]  bus_req_tag_o;
    logic [IDX_W-1:0]  bus_req_idx_o;
    logic [ID_W-1:0]   bus_req_id_o;
    message_t          bus_req_message_o;
    logic              bus_req_ack_i;
    logic              bus_rsp_vld_i;
    logic [ID_W-1:0]   bus_rsp_id_i;
    logic [WORD_W-1:0] bus_rsp_data_i;
    logic              bus_rsp_ack_o;
    logic              fill_en_o;
    logic [TAG_W-1:0]  fill_tag_o;
    logic [IDX_W-1:0]  fill_idx_o;
    logic [WORD_W-1:0] fill_data_o;
    logic              fill_dty_o;

    int n_chk  = 0;
    int n_fail = 0;

    dcache_mshr_file #(
        .MSHR_NUM (MSHR_NUM),
        .TAG_W    (TAG_W),
        .IDX_W    (IDX_W),
        .WORD_W   (WORD_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_en_i        (alloc_en_i),
        .alloc_tag_i       (alloc_tag_i),
        .alloc_idx_i       (alloc_idx_i),
        .alloc_st_i        (alloc_st_i),
        .alloc_data_i      (alloc_data_i),
        .alloc_ack_o       (alloc_ack_o),
        .alloc_merge_o     (alloc_merge_o),
        .full_o            (full_o),
        .bus_req_en_o      (bus_req_en_o),
        .bus_req_tag_o     (bus_req_tag_o),
        .bus_req_idx_o     (bus_req_idx_o),
        .bus_req_id_o      (bus_req_id_o),
        .bus_req_message_o (bus_req_message_o),
        .bus_req_ack_i     (bus_req_ack_i),
        .bus_rsp_vld_i     (bus_rsp_vld_i),
        .bus_rsp_id_i      (bus_rsp_id_i),
        .bus_rsp_data_i    (bus_rsp_data_i),
        .bus_rsp_ack_o     (bus_rsp_ack_o),
        .fill_en_o         (fill_en_o),
        .fill_tag_o        (fill_tag_o),
        .fill_idx_o        (fill_idx_o),
        .fill_data_o       (fill_data_o),
        .fill_dty_o        (fill_dty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_en_i     = 1'b0;
        alloc_tag_i    = '0;
        alloc_idx_i    = '0;
        alloc_st_i     = 1'b0;
        alloc_data_i   = '0;
        bus_req_ack_i  = 1'b0;
        bus_rsp_vld_i  = 1'b0;
        bus_rsp_id_i   = '0;
        bus_rsp_data_i = '0;
    endtask

    // Advance to the next falling edge with all inputs idle.
    task automatic nxt();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic alloc(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] x,
                         input logic st, input logic [WORD_W-1:0] d);
        alloc_en_i   = 1'b1;
        alloc_tag_i  = t;
        alloc_idx_i  = x;
        alloc_st_i   = st;
        alloc_data_i = d;
    endtask

    task automatic rsp(input logic [ID_W-1:0] id, input logic [WORD_W-1:0] d);
        bus_rsp_vld_i  = 1'b1;
        bus_rsp_id_i   = id;
        bus_rsp_data_i = d;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack",    64'(alloc_ack_o), 64'd0);
        chk("rst_full",   64'(full_o), 64'd0);
        chk("rst_req_en", 64'(bus_req_en_o), 64'd0);
        chk("rst_fill",   64'(fill_en_o), 64'd0);

        // ---- single load miss -------------------------------------------
        nxt(); rst = 1'b1;
        alloc(10'h12, 3'd3, 1'b0, '0); #1;
        chk("t1_ack",    64'(alloc_ack_o), 64'd1);
        chk("t1_merge",  64'(alloc_merge_o), 64'd0);
        chk("t1_no_req", 64'(bus_req_en_o), 64'd0);
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t1_req_en",  64'(bus_req_en_o), 64'd1);
        chk("t1_req_id",  64'(bus_req_id_o), 64'd0);
        chk("t1_req_tag", 64'(bus_req_tag_o), 64'h12);
        chk("t1_req_idx", 64'(bus_req_idx_o), 64'd3);
        chk("t1_req_msg", 64'(bus_req_message_o), 64'(GET_S));
        nxt(); rsp(2'd0, 64'hDEAD); #1;
        chk("t1_req_gone", 64'(bus_req_en_o), 64'd0);
        chk("t1_rsp_ack",  64'(bus_rsp_ack_o), 64'd1);
        nxt(); #1;
        chk("t1_fill_en",   64'(fill_en_o), 64'd1);
        chk("t1_fill_data", fill_data_o, 64'hDEAD);
        chk("t1_fill_dty",  64'(fill_dty_o), 64'd0);
        chk("t1_fill_tag",  64'(fill_tag_o), 64'h12);
        chk("t1_fill_idx",  64'(fill_idx_o), 64'd3);
        nxt(); rsp(2'd0, 64'h1); #1;
        chk("t1_fill_once", 64'(fill_en_o), 64'd0);
        chk("t1_freed",     64'(bus_rsp_ack_o), 64'd0);

        // ---- load then store merge while PENDING ------------------------
        nxt(); alloc(10'h20, 3'd1, 1'b0, '0); #1;
        chk("t2_ack", 64'(alloc_ack_o), 64'd1);
        nxt(); alloc(10'h20, 3'd1, 1'b1, 64'h55); #1;
        chk("t2_merge_ack", 64'(alloc_ack_o), 64'd1);
        chk("t2_merge",     64'(alloc_merge_o), 64'd1);
        chk("t2_msg_pre",   64'(bus_req_message_o), 64'(GET_S));
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t2_msg_getm", 64'(bus_req_message_o), 64'(GET_M));
        chk("t2_req_id",   64'(bus_req_id_o), 64'd0);
        nxt(); rsp(2'd0, 64'hAA); #1;
        chk("t2_rsp_ack", 64'(bus_rsp_ack_o), 64'd1);
        nxt(); #1;
        chk("t2_fill_en",   64'(fill_en_o), 64'd1);
        chk("t2_fill_data", fill_data_o, 64'h55);
        chk("t2_fill_dty",  64'(fill_dty_o), 64'd1);

        // ---- store to a line ISSUED with GET_S stalls until free --------
        nxt(); alloc(10'h30, 3'd2, 1'b0, '0); #1;
        chk("t3_ack", 64'(alloc_ack_o), 64'd1);
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t3_req_id",  64'(bus_req_id_o), 64'd0);
        chk("t3_req_msg", 64'(bus_req_message_o), 64'(GET_S));
        nxt(); alloc(10'h30, 3'd2, 1'b1, 64'h1234); #1;
        chk("t3_st_stall", 64'(alloc_ack_o), 64'd0);
        chk("t3_st_nomrg", 64'(alloc_merge_o), 64'd0);
        nxt(); alloc(10'h30, 3'd2, 1'b0, '0); #1;
        chk("t3_ld_ack",   64'(alloc_ack_o), 64'd1);
        chk("t3_ld_merge", 64'(alloc_merge_o), 64'd1);
        nxt(); alloc(10'h30, 3'd2, 1'b1, 64'h1234); rsp(2'd0, 64'h77); #1;
        chk("t3_st_stall2", 64'(alloc_ack_o), 64'd0);
        chk("t3_rsp_ack",   64'(bus_rsp_ack_o), 64'd1);
        nxt(); alloc(10'h30, 3'd2, 1'b1, 64'h1234); #1;
        chk("t3_fill_stall", 64'(alloc_ack_o), 64'd0);
        chk("t3_fill_en",    64'(fill_en_o), 64'd1);
        chk("t3_fill_data",  fill_data_o, 64'h77);
        chk("t3_fill_dty",   64'(fill_dty_o), 64'd0);
        nxt(); alloc(10'h30, 3'd2, 1'b1, 64'h1234); #1;
        chk("t3_realloc",    64'(alloc_ack_o), 64'd1);
        chk("t3_realloc_nm", 64'(alloc_merge_o), 64'd0);
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t3_req2_id",  64'(bus_req_id_o), 64'd0);
        chk("t3_req2_msg", 64'(bus_req_message_o), 64'(GET_M));
        nxt(); rsp(2'd0, 64'h99); #1;
        chk("t3_rsp2_ack", 64'(bus_rsp_ack_o), 64'd1);
        nxt(); #1;
        chk("t3_fill2_data", fill_data_o, 64'h1234);
        chk("t3_fill2_dty",  64'(fill_dty_o), 64'd1);

        // ---- reset asserted with an entry ISSUED ------------------------
        nxt(); alloc(10'h40, 3'd0, 1'b0, '0); #1;
        chk("t6_ack0", 64'(alloc_ack_o), 64'd1);
        nxt(); alloc(10'h41, 3'd0, 1'b0, '0); bus_req_ack_i = 1'b1; #1;
        chk("t6_ack1",   64'(alloc_ack_o), 64'd1);
        chk("t6_req_id", 64'(bus_req_id_o), 64'd0);
        nxt(); rsp(2'd0, 64'h5); #1;
        chk("t6_pre_req_id", 64'(bus_req_id_o), 64'd1);
        chk("t6_pre_rsp",    64'(bus_rsp_ack_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("t6_req_en",  64'(bus_req_en_o), 64'd0);
        chk("t6_req_id0", 64'(bus_req_id_o), 64'd0);
        chk("t6_req_tag", 64'(bus_req_tag_o), 64'd0);
        chk("t6_rsp_ack", 64'(bus_rsp_ack_o), 64'd0);
        chk("t6_full",    64'(full_o), 64'd0);
        chk("t6_fill",    64'(fill_en_o), 64'd0);

        // ---- fill all entries, round-robin issue ------------------------
        nxt(); rst = 1'b1; alloc(10'h50, 3'd0, 1'b0, '0); #1;
        chk("t4_ack0", 64'(alloc_ack_o), 64'd1);
        nxt(); alloc(10'h51, 3'd0, 1'b0, '0); #1;
        chk("t4_ack1",    64'(alloc_ack_o), 64'd1);
        chk("t4_req_id0", 64'(bus_req_id_o), 64'd0);
        chk("t4_req_tag", 64'(bus_req_tag_o), 64'h50);
        nxt(); alloc(10'h52, 3'd0, 1'b0, '0); #1;
        chk("t4_ack2", 64'(alloc_ack_o), 64'd1);
        nxt(); alloc(10'h53, 3'd0, 1'b0, '0); #1;
        chk("t4_ack3",  64'(alloc_ack_o), 64'd1);
        chk("t4_nfull", 64'(full_o), 64'd0);
        nxt(); alloc(10'h54, 3'd0, 1'b0, '0); #1;
        chk("t4_full",      64'(full_o), 64'd1);
        chk("t4_ack_full",  64'(alloc_ack_o), 64'd0);
        chk("t4_req_held",  64'(bus_req_id_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            nxt(); bus_req_ack_i = 1'b1; #1;
            chk("t4_grant_en",  64'(bus_req_en_o), 64'd1);
            chk("t4_grant_id",  64'(bus_req_id_o), 64'(k));
            chk("t4_grant_tag", 64'(bus_req_tag_o), 64'h50 + 64'(k));
        end
        nxt(); #1;
        chk("t4_all_issued", 64'(bus_req_en_o), 64'd0);

        // ---- out-of-order responses -------------------------------------
        nxt(); rsp(2'd2, 64'hD2); #1;
        chk("t5_rsp2", 64'(bus_rsp_ack_o), 64'd1);
        nxt(); rsp(2'd0, 64'hD0); #1;
        chk("t5_rsp0",   64'(bus_rsp_ack_o), 64'd1);
        chk("t5_f2_tag", 64'(fill_tag_o), 64'h52);
        chk("t5_f2_dat", fill_data_o, 64'hD2);
        nxt(); rsp(2'd3, 64'hD3); #1;
        chk("t5_rsp3",   64'(bus_rsp_ack_o), 64'd1);
        chk("t5_f0_tag", 64'(fill_tag_o), 64'h50);
        chk("t5_f0_dat", fill_data_o, 64'hD0);
        nxt(); rsp(2'd1, 64'hD1); #1;
        chk("t5_rsp1",   64'(bus_rsp_ack_o), 64'd1);
        chk("t5_f3_tag", 64'(fill_tag_o), 64'h53);
        chk("t5_f3_dat", fill_data_o, 64'hD3);
        nxt(); rsp(2'd2, 64'hBAD); #1;
        chk("t5_bogus",  64'(bus_rsp_ack_o), 64'd0);
        chk("t5_f1_tag", 64'(fill_tag_o), 64'h51);
        chk("t5_f1_dat", fill_data_o, 64'hD1);
        nxt(); #1;
        chk("t5_fill_done", 64'(fill_en_o), 64'd0);
        chk("t5_nfull",     64'(full_o), 64'd0);

        // ---- pointer wrapped to 0 after granting id 3 -------------------
        nxt(); alloc(10'h60, 3'd0, 1'b0, '0); #1;
        nxt(); alloc(10'h61, 3'd0, 1'b0, '0); #1;
        chk("t4_wrap_id0", 64'(bus_req_id_o), 64'd0);
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t4_wrap_g0", 64'(bus_req_id_o), 64'd0);
        nxt(); bus_req_ack_i = 1'b1; #1;
        chk("t4_wrap_g1", 64'(bus_req_id_o), 64'd1);
        chk("t4_wrap_tag", 64'(bus_req_tag_o), 64'h61);

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
